// File: rtl/instruction_fetch.sv
// ============================================================================
// Module  : instruction_fetch
// Brief   : IF stage - owns fetch PC, issues imem word reads, buffers results
//           in a 2-entry FWFT FIFO toward decode; redirect flushes wrong path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_next
);

    localparam logic [0:0] S_RESET = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_addr_q, inflight_addr_d;
    logic        drop_q, drop_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic        w_credit_ok;
    logic        w_not_empty;
    logic [2:0]  w_occupancy;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_head_pc;

    // Occupancy counts the in-flight read as a reserved slot so a response
    // can never arrive into a full FIFO.
    assign w_occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_credit_ok   = (w_occupancy < 3'd2);
    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
    assign w_not_empty   = (count_q != 2'd0);
    assign w_accept      = imem_req & imem_ready;
    assign w_pop         = out_valid & out_ready;
    assign w_push        = inflight_q & ~drop_q & ~redirect;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_RESET;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc_q;
        if (state_q == S_RUN) begin
            imem_req = w_credit_ok;
        end
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        inflight_d      = w_accept;
        inflight_addr_d = w_accept ? fetch_pc_q : inflight_addr_q;
        drop_d          = drop_q;
        fifo_pc_d       = fifo_pc_q;
        fifo_instr_d    = fifo_instr_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;

        if (redirect) begin
            fetch_pc_d = w_redirect_pc;
            // A read accepted this cycle is wrong-path; a response landing now
            // is discarded by the flush itself.
            drop_d     = w_accept;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (w_accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (inflight_q) begin
                drop_d = 1'b0;
            end
            if (w_push) begin
                fifo_pc_d[wr_ptr_q]    = inflight_addr_q;
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d               = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= 32'd0;
            drop_q          <= 1'b0;
            fifo_pc_q[0]    <= 32'd0;
            fifo_pc_q[1]    <= 32'd0;
            fifo_instr_q[0] <= 32'd0;
            fifo_instr_q[1] <= 32'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            drop_q          <= drop_d;
            fifo_pc_q       <= fifo_pc_d;
            fifo_instr_q    <= fifo_instr_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
        end
    end

    // ---------------- Decode-side outputs ----------------
    assign w_head_pc   = w_not_empty ? fifo_pc_q[rd_ptr_q] : 32'd0;
    assign out_valid   = w_not_empty & ~redirect;
    assign pc          = w_head_pc;
    assign instruction = w_not_empty ? fifo_instr_q[rd_ptr_q] : 32'd0;
    assign pc_next     = w_not_empty ? (w_head_pc + 32'd4) : 32'd0;

    a_no_push_into_full : assert property (
        @(posedge clk) disable iff (rst) !(w_push && (count_q == 2'd2))
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module  : tb_instruction_fetch
// Brief   : Scoreboard bench for instruction_fetch with a 1-cycle imem model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_next;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] exp_req_pc;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc          (pc),
        .instruction (instruction),
        .pc_next     (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model + scoreboard: requests are checked against the expected
    // fetch stream; every delivered transfer is popped and compared.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] exp_next;
        item_t       it;
        exp_req_pc = RESET_PC;
        imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_ready;
            acc_addr = imem_addr;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected: got pc=%h instr=%h, expected no transfer", pc, instruction);
                end else begin
                    it       = exp_q.pop_front();
                    exp_next = it.pc + 32'd4;
                    if (pc !== it.pc || instruction !== it.instr || pc_next !== exp_next) begin
                        n_fail++;
                        $display("FAIL xfer_data: got pc=%h instr=%h pc_next=%h, expected pc=%h instr=%h pc_next=%h",
                                 pc, instruction, pc_next, it.pc, it.instr, exp_next);
                    end
                end
            end
            if (rst) begin
                exp_q.delete();
                exp_req_pc = RESET_PC;
            end else if (redirect) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redirect_valid: got out_valid=%b, expected 0", out_valid);
                end
                exp_q.delete();
                exp_req_pc = redirect_pc & ~32'h3;
            end else if (acc) begin
                n_checks++;
                if (acc_addr !== exp_req_pc) begin
                    n_fail++;
                    $display("FAIL req_addr: got %h, expected %h", acc_addr, exp_req_pc);
                end
                it.pc    = exp_req_pc;
                it.instr = mem_word(exp_req_pc);
                exp_q.push_back(it);
                exp_req_pc = exp_req_pc + 32'd4;
            end
            @(posedge clk);
            #1;
            imem_rdata = acc ? mem_word(acc_addr) : 32'hDEAD_BEEF;
        end
    end

    task automatic test_reset();
        repeat (3) step();
        #1;
        n_checks++;
        if ({imem_req, out_valid, pc, instruction, pc_next} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b valid=%b pc=%h instr=%h pc_next=%h, expected all 0",
                     imem_req, out_valid, pc, instruction, pc_next);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL cycle0_req: got %b, expected 0", imem_req);
        end
        step(); #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL cycle1_req: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        step(); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cycle2_valid: got %b, expected 0", out_valid);
        end
        step(); #1;
        n_checks++;
        if (out_valid !== 1'b1 || pc !== RESET_PC || pc_next !== RESET_PC + 32'd4 ||
            instruction !== mem_word(RESET_PC)) begin
            n_fail++;
            $display("FAIL cycle3_out: got valid=%b pc=%h pc_next=%h instr=%h, expected 1 %h %h %h",
                     out_valid, pc, pc_next, instruction, RESET_PC, RESET_PC + 32'd4, mem_word(RESET_PC));
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) begin
            step(); #1;
            n_checks++;
            if (out_valid !== 1'b1 || pc !== RESET_PC + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL back_to_back: got valid=%b pc=%h, expected 1 %h", out_valid, pc, RESET_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        step();
        out_ready = 1'b0;
        #1;
        held = pc;
        repeat (5) step();
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1 || pc !== held) begin
            n_fail++;
            $display("FAIL backpressure_hold: got req=%b valid=%b pc=%h, expected 0 1 %h", imem_req, out_valid, pc, held);
        end
        out_ready = 1'b1;
        step(); #1;
        n_checks++;
        if (out_valid !== 1'b1 || pc !== held + 32'd4) begin
            n_fail++;
            $display("FAIL backpressure_release: got valid=%b pc=%h, expected 1 %h", out_valid, pc, held + 32'd4);
        end
        repeat (5) step();
    endtask

    task automatic test_imem_stall();
        logic [31:0] a;
        step();
        imem_ready = 1'b0;
        #1;
        a = imem_addr;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_req: got %b, expected 1", imem_req);
        end
        for (int k = 0; k < 2; k++) begin
            step(); #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                n_fail++;
                $display("FAIL stall_addr: got req=%b addr=%h, expected 1 %h", imem_req, imem_addr, a);
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got out_valid=%b, expected 0", out_valid);
        end
        imem_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic wait_deliver(input logic [31:0] want, input string name);
        int k = 0;
        while (!(out_valid === 1'b1 && pc === want) && k < 20) begin
            step(); #1;
            k++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || pc !== want) begin
            n_fail++;
            $display("FAIL %s: got valid=%b pc=%h, expected 1 %h", name, out_valid, pc, want);
        end
    endtask

    task automatic test_redirect();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_cycle_valid: got %b, expected 0", out_valid);
        end
        step();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL redirect_req: got req=%b addr=%h, expected 1 00002000", imem_req, imem_addr);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_stale: got out_valid=%b pc=%h, expected 0", out_valid, pc);
        end
        wait_deliver(32'h0000_2000, "redirect_first");
        repeat (2) step();
        // Back-to-back redirects: the last target wins.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        step();
        redirect_pc = 32'h0000_4008;
        step();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_4008) begin
            n_fail++;
            $display("FAIL b2b_redirect_req: got req=%b addr=%h, expected 1 00004008", imem_req, imem_addr);
        end
        wait_deliver(32'h0000_4008, "b2b_redirect_first");
        repeat (3) step();
    endtask

    task automatic test_wrap();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        wait_deliver(32'hFFFF_FFFC, "wrap_last");
        n_checks++;
        if (pc_next !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_pc_next: got %h, expected 00000000", pc_next);
        end
        step(); #1;
        n_checks++;
        if (out_valid !== 1'b1 || pc !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_next_pc: got valid=%b pc=%h, expected 1 00000000", out_valid, pc);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        step();
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || pc !== 32'd0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got valid=%b pc=%h req=%b, expected 0 0 0", out_valid, pc, imem_req);
        end
        wait_deliver(RESET_PC, "reset_mid_first");
        n_checks++;
        if (instruction !== mem_word(RESET_PC)) begin
            n_fail++;
            $display("FAIL reset_mid_instr: got %h, expected %h", instruction, mem_word(RESET_PC));
        end
        repeat (4) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        imem_ready  = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_imem_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
